lsu_axi_burst_master: RTL

Parametrised AXI4 burst master for the TPU load/store path. It accepts one load or store command (address, beat count, direction) and splits it into INCR bursts capped at MAX_BURST beats that never cross a 4 KB boundary. Read beats stream out to the local buffer and write beats stream in from it. It reports completion and sticky error status, and drives wfi high when idle.

---
 rtl/lsu_axi_burst_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lsu_axi_burst_master.sv
// lsu_axi_burst_master: splits one load/store command into AXI4 INCR bursts of at most MAX_BURST beats that never cross 4 KB
// Ports: clk/rst (async active-high); cmd_* command handshake; AW/W/B and AR/R AXI4 master channels;
//        ld_* load beats to the local buffer; st_* store beats from it; done pulse, sticky err, wfi when idle.
module lsu_axi_burst_master #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 12,
  parameter int AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ID_WIDTH-1:0]   AWID,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [3:0]            AWREGION,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [ID_WIDTH-1:0]   BID,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ID_WIDTH-1:0]   ARID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic [3:0]            ARREGION,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [ID_WIDTH-1:0]   RID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_vld,
  output logic                  ld_last,
  input  logic                  ld_rdy,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [STRB_WIDTH-1:0] st_strb,
  input  logic                  st_vld,
  output logic                  st_rdy,
  output logic                  done,
  output logic                  err,
  output logic                  wfi
);
  localparam int SZ = $clog2(STRB_WIDTH);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmd_addr_al;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]            len_q, len_d, beat_q, beat_d, next_len;
  logic                  err_q, err_d, last_beat, more, ax_hs, unused;
  // Beats of the next burst minus one: limited by what is left, MAX_BURST and the distance to the 4 KB page end.
  function automatic logic [7:0] len_of(input logic [ADDR_WIDTH-1:0] a, input logic [LEN_WIDTH-1:0] r);
    logic [12:0] page;
    int b;
    page = (13'd4096 - {1'b0, a[11:0]}) >> SZ;
    b = int'(r);
    if (b > MAX_BURST) b = MAX_BURST;
    if (b > int'(page)) b = int'(page);
    return 8'(b - 1);
  endfunction
  assign cmd_addr_al = {cmd_addr[ADDR_WIDTH-1:SZ], SZ'(0)};
  assign last_beat   = beat_q == len_q;
  assign more        = rem_q != '0;
  assign next_len    = more ? len_of(addr_q, rem_q) : len_q;
  assign ax_hs       = (state_q == RD_ADDR && ARREADY) || (state_q == WR_ADDR && AWREADY);
  assign unused      = ^{BID, RID, cmd_addr[SZ-1:0]};
  assign AWID     = ID_WIDTH'(AXI_ID);
  assign ARID     = ID_WIDTH'(AXI_ID);
  assign AWADDR   = addr_q;
  assign ARADDR   = addr_q;
  assign AWLEN    = len_q;
  assign ARLEN    = len_q;
  assign AWSIZE   = 3'(SZ);
  assign ARSIZE   = 3'(SZ);
  assign AWBURST  = 2'b01;
  assign ARBURST  = 2'b01;
  assign AWREGION = '0;
  assign ARREGION = '0;
  assign AWVALID  = state_q == WR_ADDR;
  assign ARVALID  = state_q == RD_ADDR;
  assign WDATA    = st_data;
  assign WSTRB    = st_strb;
  assign WVALID   = state_q == WR_DATA && st_vld;
  assign WLAST    = state_q == WR_DATA && last_beat;
  assign st_rdy   = state_q == WR_DATA && WREADY;
  assign BREADY   = state_q == WR_RESP;
  assign RREADY   = state_q == RD_DATA && ld_rdy;
  assign ld_data  = RDATA;
  assign ld_vld   = state_q == RD_DATA && RVALID;
  assign ld_last  = ld_vld && last_beat && !more;
  assign cmd_rdy  = state_q == IDLE;
  assign wfi      = state_q == IDLE;
  assign done     = state_q == DONE;
  assign err      = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (cmd_vld) begin
        addr_d  = cmd_addr_al;
        rem_d   = cmd_beats;
        err_d   = 1'b0;
        len_d   = cmd_beats == '0 ? len_q : len_of(cmd_addr_al, cmd_beats);
        state_d = cmd_beats == '0 ? DONE : cmd_wr ? WR_ADDR : RD_ADDR;
      end
      RD_ADDR, WR_ADDR: if (ax_hs) begin
        addr_d  = addr_q + ADDR_WIDTH'((32'(len_q) + 32'd1) << SZ);
        rem_d   = rem_q - LEN_WIDTH'(32'(len_q) + 32'd1);
        beat_d  = '0;
        state_d = state_q == RD_ADDR ? RD_DATA : WR_DATA;
      end
      RD_DATA: if (RVALID && ld_rdy) begin
        // RLAST is checked against our own beat count, not trusted to end the burst.
        err_d  = err_q | (RRESP != 2'b00) | (RLAST != last_beat);
        beat_d = beat_q + 8'd1;
        if (last_beat) begin
          state_d = more ? RD_ADDR : DONE;
          len_d   = next_len;
        end
      end
      WR_DATA: if (st_vld && WREADY) begin
        beat_d = beat_q + 8'd1;
        if (last_beat) state_d = WR_RESP;
      end
      WR_RESP: if (BVALID) begin
        err_d   = err_q | (BRESP != 2'b00);
        state_d = more ? WR_ADDR : DONE;
        len_d   = next_len;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end
endmodule
